// File: rtl/master_qp_update.sv
// Per-block master QP update: rate delta + fullness bias (or flatness override),
// clamped to the bit-depth legal range; sof reloads the slice initial QP.
module master_qp_update #(
  parameter int MAX_QP = 72
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        bits_per_component_coded,
  input  logic              sof,
  input  logic signed [7:0] init_qp,
  input  logic [11:0]       target_bits,
  input  logic [11:0]       block_bits,
  input  logic [7:0]        buffer_fullness,
  input  logic              flatness_flag,
  input  logic              block_valid,
  output logic              block_ready,
  output logic signed [7:0] masterQp,
  output logic              masterQp_valid
);

  localparam logic signed [9:0] MAX_QP_S = 10'(MAX_QP);

  typedef enum logic {IDLE, CALC} state_e;

  state_e            state_q, state_d;
  logic signed [3:0] delta_q, delta_d;
  logic signed [7:0] qp_q, qp_d;
  logic              vld_q, vld_d;

  logic signed [9:0]  min_qp;
  logic signed [12:0] diff;
  logic signed [3:0]  rate_delta, bias, total_delta;
  logic signed [9:0]  upd_sum, init_sum;

  // Clamp in the 10-bit domain; the result always fits in 8 bits.
  function automatic logic signed [7:0] clamp_qp(input logic signed [9:0] x,
                                                 input logic signed [9:0] mn);
    logic signed [9:0] r;
    if (x > MAX_QP_S)  r = MAX_QP_S;
    else if (x < mn)   r = mn;
    else               r = x;
    return r[7:0];
  endfunction

  always_comb begin
    case (bits_per_component_coded)
      2'd0:    min_qp = 10'sd16;
      2'd1:    min_qp = 10'sd0;
      default: min_qp = -10'sd16;
    endcase
  end

  assign diff = $signed({1'b0, block_bits}) - $signed({1'b0, target_bits});

  always_comb begin
    if      (diff >= 13'sd64)  rate_delta = 4'sd3;
    else if (diff >= 13'sd32)  rate_delta = 4'sd2;
    else if (diff >= 13'sd8)   rate_delta = 4'sd1;
    else if (diff > -13'sd8)   rate_delta = 4'sd0;
    else if (diff > -13'sd32)  rate_delta = -4'sd1;
    else                       rate_delta = -4'sd2;

    if      (buffer_fullness >= 8'd224) bias = 4'sd2;
    else if (buffer_fullness >= 8'd192) bias = 4'sd1;
    else if (buffer_fullness <= 8'd32)  bias = -4'sd1;
    else                                bias = 4'sd0;

    // Flat blocks in a non-full buffer get a fixed QP drop for visual quality.
    if (flatness_flag && (buffer_fullness < 8'd192)) total_delta = -4'sd4;
    else                                             total_delta = rate_delta + bias;
  end

  assign upd_sum  = {{2{qp_q[7]}}, qp_q} + {{6{delta_q[3]}}, delta_q};
  assign init_sum = {{2{init_qp[7]}}, init_qp};

  always_comb begin
    state_d = state_q;
    delta_d = delta_q;
    qp_d    = qp_q;
    vld_d   = 1'b0;
    if (sof) begin
      qp_d    = clamp_qp(init_sum, min_qp);
      vld_d   = 1'b1;
      delta_d = 4'sd0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (block_valid) begin
          delta_d = total_delta;
          state_d = CALC;
        end
        CALC: begin
          qp_d    = clamp_qp(upd_sum, min_qp);
          vld_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      delta_q <= 4'sd0;
      qp_q    <= 8'sd0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      delta_q <= delta_d;
      qp_q    <= qp_d;
      vld_q   <= vld_d;
    end
  end

  assign block_ready    = (state_q == IDLE);
  assign masterQp       = qp_q;
  assign masterQp_valid = vld_q;

endmodule

// File: tb/tb_master_qp_update.sv
// Scoreboard bench for master_qp_update: expected QPs queued at stimulus, checked on valid.
module tb_master_qp_update;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        bpc = 2'd1;
  logic              sof = 1'b0;
  logic signed [7:0] init_qp = 8'sd0;
  logic [11:0]       target_bits = 12'd256;
  logic [11:0]       block_bits = 12'd0;
  logic [7:0]        fullness = 8'd128;
  logic              flat = 1'b0;
  logic              block_valid = 1'b0;
  logic              block_ready;
  logic signed [7:0] masterQp;
  logic              masterQp_valid;

  int n_chk = 0;
  int n_fail = 0;
  int sbq[$];
  int model_qp = 0;

  master_qp_update #(.MAX_QP(72)) dut (
    .clk(clk), .rst(rst), .bits_per_component_coded(bpc), .sof(sof),
    .init_qp(init_qp), .target_bits(target_bits), .block_bits(block_bits),
    .buffer_fullness(fullness), .flatness_flag(flat), .block_valid(block_valid),
    .block_ready(block_ready), .masterQp(masterQp), .masterQp_valid(masterQp_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int minq(input int c);
    return (c == 0) ? 16 : (c == 1) ? 0 : -16;
  endfunction

  function automatic int clampm(input int v, input int c);
    if (v > 72) return 72;
    if (v < minq(c)) return minq(c);
    return v;
  endfunction

  function automatic int delta_m(input int bb, input int tg, input int fl, input int fz);
    int d, r, b;
    d = bb - tg;
    if (fz != 0 && fl < 192) return -4;
    r = (d >= 64) ? 3 : (d >= 32) ? 2 : (d >= 8) ? 1 : (d > -8) ? 0 : (d > -32) ? -1 : -2;
    b = (fl >= 224) ? 2 : (fl >= 192) ? 1 : (fl <= 32) ? -1 : 0;
    return r + b;
  endfunction

  // Scoreboard consumer: every valid pulse must match the oldest queued value.
  always @(negedge clk) begin
    if (!rst && masterQp_valid) begin
      if (sbq.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("sb_qp", int'(masterQp), sbq.pop_front());
    end
  end

  task automatic send_sof(input int code, input int iq);
    @(negedge clk);
    bpc = 2'(code); init_qp = 8'(iq); sof = 1'b1;
    model_qp = clampm(iq, code);
    sbq.push_back(model_qp);
    @(negedge clk);
    sof = 1'b0;
    chk("ready_after_sof", int'(block_ready), 1);
  endtask

  task automatic send_block(input int bb, input int fl, input int fz);
    @(negedge clk);
    chk("ready_before_accept", int'(block_ready), 1);
    block_bits = 12'(bb); fullness = 8'(fl); flat = fz[0]; block_valid = 1'b1;
    model_qp = clampm(model_qp + delta_m(bb, 256, fl, fz), int'(bpc));
    sbq.push_back(model_qp);
    @(negedge clk);
    block_valid = 1'b0;
    chk("ready_low_calc", int'(block_ready), 0);
    chk("no_early_valid", int'(masterQp_valid), 0);
    @(negedge clk);
    chk("ready_high_after", int'(block_ready), 1);
  endtask

  initial begin
    #1;
    chk("rst_qp", int'(masterQp), 0);
    chk("rst_valid", int'(masterQp_valid), 0);
    chk("rst_ready", int'(block_ready), 1);
    #20 rst = 1'b0;

    send_sof(1, 40);
    chk("sof_qp40", int'(masterQp), 40);
    send_block(300, 128, 0);
    chk("rate_plus2", int'(masterQp), 42);

    send_sof(1, 71);
    send_block(356, 240, 0);
    chk("upper_clamp", int'(masterQp), 72);

    send_sof(2, -15);
    send_block(156, 10, 0);
    chk("lower_clamp_c2", int'(masterQp), -16);
    send_sof(0, 17);
    send_block(156, 10, 0);
    chk("lower_clamp_c0", int'(masterQp), 16);

    send_sof(1, 50);
    send_block(336, 100, 1);
    chk("flat_override", int'(masterQp), 46);
    send_sof(1, 50);
    send_block(336, 200, 1);
    chk("flat_full", int'(masterQp), 54);

    send_sof(1, 120);
    chk("init_clamp", int'(masterQp), 72);

    // Block accepted, then a second block_valid during CALC must be ignored.
    send_sof(1, 20);
    @(negedge clk);
    block_bits = 12'd400; fullness = 8'd128; flat = 1'b0; block_valid = 1'b1;
    model_qp = clampm(model_qp + delta_m(400, 256, 128, 0), 1);
    sbq.push_back(model_qp);
    @(negedge clk);
    block_bits = 12'd0; fullness = 8'd10;
    @(negedge clk);
    block_valid = 1'b0;
    @(negedge clk);
    chk("ignore_in_calc", int'(masterQp), 23);

    // sof during CALC aborts the pending update.
    @(negedge clk);
    block_bits = 12'd400; fullness = 8'd240; block_valid = 1'b1;
    @(negedge clk);
    sof = 1'b1; init_qp = 8'sd30; bpc = 2'd1;
    model_qp = 30; sbq.push_back(30);
    @(negedge clk);
    sof = 1'b0; block_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sof_abort", int'(masterQp), 30);

    // sof and block_valid together: block dropped.
    @(negedge clk);
    sof = 1'b1; init_qp = 8'sd10; block_valid = 1'b1; block_bits = 12'd400;
    model_qp = 10; sbq.push_back(10);
    @(negedge clk);
    sof = 1'b0; block_valid = 1'b0;
    chk("sof_wins_ready", int'(block_ready), 1);
    repeat (3) @(negedge clk);
    chk("sof_wins_qp", int'(masterQp), 10);

    // Reset mid-CALC: no pulse, state back to reset values.
    @(negedge clk);
    block_valid = 1'b1; block_bits = 12'd400;
    @(negedge clk);
    block_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_qp", int'(masterQp), 0);
    chk("midrst_ready", int'(block_ready), 1);
    chk("midrst_valid", int'(masterQp_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_hold", int'(masterQp), 0);

    // Random blocks against the model.
    send_sof(1, 36);
    for (int i = 0; i < 10; i++)
      send_block(int'($urandom_range(0, 600)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 3) == 0));
    chk("rand_final_qp", int'(masterQp), model_qp);

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
